pipe_stage_buf: RTL

Parametrised pipeline-stage register for the boundary between two stages (IF/ID first, reusable at ID/EX and later). It carries an instruction word and its PC with a valid/ready handshake, a 2-entry skid buffer for stalls, and synchronous flush. Its output is a NOP-encoded bubble whenever no valid entry is held. It also provides the PC-plus-step value and saturating stall/flush counters for performance monitoring.

---
 rtl/pipe_stage_buf.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
// It also supports synchronous flush, NOP bubble output, PC+step output and saturating perf counters.
module pipe_stage_buf #(
    parameter int                DATA_W  = 32,
    parameter int                PC_W    = 32,
    parameter int                PC_STEP = 4,
    parameter logic [DATA_W-1:0] BUBBLE  = 32'hFC00_0000,
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc_next,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

    localparam logic [PC_W-1:0]  STEP_C    = PC_W'(PC_STEP);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    occ_e              state_r;
    occ_e              state_nx_s;
    logic              in_ready_r;
    logic [DATA_W-1:0] main_data_r;
    logic [PC_W-1:0]   main_pc_r;
    logic [PC_W-1:0]   main_pc_next_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [PC_W-1:0]   skid_pc_r;
    logic [PC_W-1:0]   skid_pc_next_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic              out_valid_s;
    logic              push_s;
    logic              pop_s;
    logic              load_main_in_s;
    logic              load_main_skid_s;
    logic              load_skid_s;

    assign out_valid_s = (state_r != ST_EMPTY);
    assign push_s      = in_valid & in_ready_r;
    assign pop_s       = out_valid_s & out_ready;

    // Occupancy next-state and register load selects; flush overrides push/pop.
    always_comb begin
        state_nx_s       = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nx_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_nx_s     = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nx_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        state_nx_s     = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else if (push_s) begin
                        state_nx_s  = ST_TWO;
                        load_skid_s = 1'b1;
                    end else if (pop_s) begin
                        state_nx_s = ST_EMPTY;
                    end else begin
                        state_nx_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        state_nx_s       = ST_ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nx_s = ST_TWO;
                    end
                end
                default: begin
                    state_nx_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state and registered in_ready (depends only on next state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            in_ready_r <= (state_nx_s != ST_TWO);
        end
    end

    // Head register; PC+step is precomputed on load so the output path is mux-only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_r    <= {DATA_W{1'b0}};
            main_pc_r      <= {PC_W{1'b0}};
            main_pc_next_r <= {PC_W{1'b0}};
        end else if (load_main_in_s) begin
            main_data_r    <= in_data;
            main_pc_r      <= in_pc;
            main_pc_next_r <= in_pc + STEP_C;
        end else if (load_main_skid_s) begin
            main_data_r    <= skid_data_r;
            main_pc_r      <= skid_pc_r;
            main_pc_next_r <= skid_pc_next_r;
        end
    end

    // Skid register, filled only when the head is stalled and upstream still pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_r    <= {DATA_W{1'b0}};
            skid_pc_r      <= {PC_W{1'b0}};
            skid_pc_next_r <= {PC_W{1'b0}};
        end else if (load_skid_s) begin
            skid_data_r    <= in_data;
            skid_pc_r      <= in_pc;
            skid_pc_next_r <= in_pc + STEP_C;
        end
    end

    // Saturating performance counters; flush does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (out_valid_s && !out_ready && (stall_cnt_r != CNT_MAX_C)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
            end
            if (flush && (flush_cnt_r != CNT_MAX_C)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE_C;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_s;
    assign out_data    = out_valid_s ? main_data_r    : BUBBLE;
    assign out_pc      = out_valid_s ? main_pc_r      : {PC_W{1'b0}};
    assign out_pc_next = out_valid_s ? main_pc_next_r : {PC_W{1'b0}};
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;

endmodule
